// File: rtl/td4_decode_sequencer.sv
// td4_decode_sequencer
//   Fetch/decode/execute controller for the TTM4 4-bit CPU. It latches the
//   ROM word, selects the bus source, drives the immediate into the adder,
//   and issues the active-low store strobes and the PC controls for the
//   74HC161-style registers downstream. It also holds the carry flag.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   synchronous reset, active high
//   STEP_EN   in   advance out of FETCH (tie high to free-run)
//   ROM_DATA  in   instruction word {opcode, imm} at the current PC
//   CARRY_IN  in   adder carry-out, sampled at the end of EXEC
//   IMM       out  immediate presented to the adder
//   nA_OUT    out  bus source enable, register A (low = drive)
//   nB_OUT    out  bus source enable, register B (low = drive)
//   nIN_OUT   out  bus source enable, input port (low = drive)
//   nA_ST     out  store strobe, register A (low = load)
//   nB_ST     out  store strobe, register B (low = load)
//   nOUT_ST   out  store strobe, output port (low = load)
//   nPC_LD    out  PC parallel load from the adder result (low = load)
//   PC_INC    out  PC count enable (high = increment)
//   CFLAG     out  carry flag
//   PHASE     out  00 FETCH, 01 DECODE, 10 EXEC
module td4_decode_sequencer #(
   parameter int OPW = 4,
   parameter int IMW = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 STEP_EN,
   input  logic [OPW+IMW-1:0]   ROM_DATA,
   input  logic                 CARRY_IN,
   output logic [IMW-1:0]       IMM,
   output logic                 nA_OUT,
   output logic                 nB_OUT,
   output logic                 nIN_OUT,
   output logic                 nA_ST,
   output logic                 nB_ST,
   output logic                 nOUT_ST,
   output logic                 nPC_LD,
   output logic                 PC_INC,
   output logic                 CFLAG,
   output logic [1:0]           PHASE
);

   typedef enum logic [1:0] {
      PH_FETCH  = 2'b00,
      PH_DECODE = 2'b01,
      PH_EXEC   = 2'b10
   } phase_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_A,
      SRC_B,
      SRC_IN
   } src_t;

   typedef enum logic [2:0] {
      DST_NONE,
      DST_A,
      DST_B,
      DST_OUT,
      DST_JMP,
      DST_JNC
   } dst_t;

   localparam logic [3:0] OP_ADD_A = 4'b0000;
   localparam logic [3:0] OP_MOV_AB = 4'b0001;
   localparam logic [3:0] OP_IN_A  = 4'b0010;
   localparam logic [3:0] OP_MOV_AI = 4'b0011;
   localparam logic [3:0] OP_MOV_BA = 4'b0100;
   localparam logic [3:0] OP_ADD_B = 4'b0101;
   localparam logic [3:0] OP_IN_B  = 4'b0110;
   localparam logic [3:0] OP_MOV_BI = 4'b0111;
   localparam logic [3:0] OP_OUT_B = 4'b1001;
   localparam logic [3:0] OP_OUT_I = 4'b1011;
   localparam logic [3:0] OP_JNC   = 4'b1110;
   localparam logic [3:0] OP_JMP   = 4'b1111;

   // Bus source for an opcode
   function automatic src_t f_src(input logic [OPW-1:0] op);
      src_t s;
      s = SRC_NONE;
      case (op)
         OP_ADD_A, OP_MOV_BA:           s = SRC_A;
         OP_MOV_AB, OP_ADD_B, OP_OUT_B: s = SRC_B;
         OP_IN_A, OP_IN_B:              s = SRC_IN;
         default:                       s = SRC_NONE;
      endcase
      return s;
   endfunction

   // Register-to-register moves and input reads pass the bus through the
   // adder unchanged, so they force the immediate to zero.
   function automatic logic f_imm_zero(input logic [OPW-1:0] op);
      logic z;
      z = 1'b0;
      case (op)
         OP_MOV_AB, OP_IN_A, OP_MOV_BA, OP_IN_B, OP_OUT_B: z = 1'b1;
         default:                                          z = 1'b0;
      endcase
      return z;
   endfunction

   // Destination / PC action for an opcode
   function automatic dst_t f_dst(input logic [OPW-1:0] op);
      dst_t d;
      d = DST_NONE;
      case (op)
         OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_AI: d = DST_A;
         OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_BI: d = DST_B;
         OP_OUT_B, OP_OUT_I:                      d = DST_OUT;
         OP_JMP:                                  d = DST_JMP;
         OP_JNC:                                  d = DST_JNC;
         default:                                 d = DST_NONE;
      endcase
      return d;
   endfunction

   phase_t                 r_phase;
   logic [OPW+IMW-1:0]     r_ir;
   logic                   r_cflag;
   logic [IMW-1:0]         r_imm;
   logic                   r_na_out;
   logic                   r_nb_out;
   logic                   r_nin_out;

   logic [OPW-1:0]         w_rom_op;
   logic [IMW-1:0]         w_rom_imm;
   logic [OPW-1:0]         w_ir_op;
   src_t                   w_rom_src;
   logic                   w_rom_imm_zero;
   dst_t                   w_ir_dst;
   logic                   w_ir_is_add;
   logic                   w_exec;
   logic                   w_pc_load;

   assign w_rom_op       = ROM_DATA[OPW+IMW-1:IMW];
   assign w_rom_imm      = ROM_DATA[IMW-1:0];
   assign w_ir_op        = r_ir[OPW+IMW-1:IMW];
   assign w_rom_src      = f_src(w_rom_op);
   assign w_rom_imm_zero = f_imm_zero(w_rom_op);
   assign w_ir_dst       = f_dst(w_ir_op);
   assign w_ir_is_add    = (w_ir_op == OP_ADD_A) || (w_ir_op == OP_ADD_B);

   // Bus enables and IMM are registered on the FETCH->DECODE edge straight
   // from ROM_DATA, so they are stable for the whole of DECODE and EXEC and
   // return to idle on the EXEC->FETCH edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_phase   <= PH_FETCH;
         r_ir      <= '0;
         r_cflag   <= 1'b0;
         r_imm     <= '0;
         r_na_out  <= 1'b1;
         r_nb_out  <= 1'b1;
         r_nin_out <= 1'b1;
      end else begin
         case (r_phase)
            PH_FETCH: begin
               if (STEP_EN) begin
                  r_ir      <= ROM_DATA;
                  r_phase   <= PH_DECODE;
                  r_imm     <= w_rom_imm_zero ? '0 : w_rom_imm;
                  r_na_out  <= (w_rom_src != SRC_A);
                  r_nb_out  <= (w_rom_src != SRC_B);
                  r_nin_out <= (w_rom_src != SRC_IN);
               end
            end
            PH_DECODE: begin
               r_phase <= PH_EXEC;
            end
            PH_EXEC: begin
               r_phase   <= PH_FETCH;
               r_cflag   <= w_ir_is_add ? CARRY_IN : 1'b0;
               r_imm     <= '0;
               r_na_out  <= 1'b1;
               r_nb_out  <= 1'b1;
               r_nin_out <= 1'b1;
            end
            default: begin
               r_phase <= PH_FETCH;
            end
         endcase
      end
   end

   // Strobes are gated by ~RST combinationally so a reset landing in EXEC
   // suppresses the write within the same cycle.
   assign w_exec    = (r_phase == PH_EXEC) && !RST;
   assign w_pc_load = w_exec &&
                      ((w_ir_dst == DST_JMP) || ((w_ir_dst == DST_JNC) && !r_cflag));

   assign nA_ST   = !(w_exec && (w_ir_dst == DST_A));
   assign nB_ST   = !(w_exec && (w_ir_dst == DST_B));
   assign nOUT_ST = !(w_exec && (w_ir_dst == DST_OUT));
   assign nPC_LD  = !w_pc_load;
   assign PC_INC  = w_exec && !w_pc_load;

   assign IMM     = r_imm;
   assign nA_OUT  = r_na_out;
   assign nB_OUT  = r_nb_out;
   assign nIN_OUT = r_nin_out;
   assign CFLAG   = r_cflag;
   assign PHASE   = r_phase;

endmodule

// File: tb/tb_td4_decode_sequencer.sv
// tb_td4_decode_sequencer
//   Scoreboard bench for td4_decode_sequencer. The driver issues
//   instructions and pushes the reference response; a negedge monitor pops
//   and compares whenever the DUT is in DECODE/EXEC.
module tb_td4_decode_sequencer;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       STEP_EN = 1'b0;
   logic [7:0] ROM_DATA = 8'h00;
   logic       CARRY_IN = 1'b0;
   logic [3:0] IMM;
   logic       nA_OUT, nB_OUT, nIN_OUT;
   logic       nA_ST, nB_ST, nOUT_ST, nPC_LD, PC_INC, CFLAG;
   logic [1:0] PHASE;

   td4_decode_sequencer #(.OPW(4), .IMW(4)) dut (
      .CLK(CLK), .RST(RST), .STEP_EN(STEP_EN), .ROM_DATA(ROM_DATA),
      .CARRY_IN(CARRY_IN), .IMM(IMM), .nA_OUT(nA_OUT), .nB_OUT(nB_OUT),
      .nIN_OUT(nIN_OUT), .nA_ST(nA_ST), .nB_ST(nB_ST), .nOUT_ST(nOUT_ST),
      .nPC_LD(nPC_LD), .PC_INC(PC_INC), .CFLAG(CFLAG), .PHASE(PHASE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [2:0] bus_n;   // {nA_OUT, nB_OUT, nIN_OUT}
      logic [3:0] imm;
      logic [3:0] st_n;    // {nA_ST, nB_ST, nOUT_ST, nPC_LD}
      logic       pc_inc;
      logic       cflag;   // flag value after EXEC
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;
   bit   cf_pending = 1'b0;
   logic cf_exp = 1'b0;
   logic m_cflag = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Reference: the instruction table written out mnemonic by mnemonic.
   function automatic exp_t model(input logic [7:0] ir, input logic carry, input logic cf_before);
      exp_t e;
      logic [3:0] op;
      op       = ir[7:4];
      e.bus_n  = 3'b111;
      e.imm    = ir[3:0];
      e.st_n   = 4'b1111;
      e.pc_inc = 1'b1;
      e.cflag  = 1'b0;
      case (op)
         4'h0: begin e.bus_n = 3'b011; e.st_n = 4'b0111; e.cflag = carry; end        // ADD A,Im
         4'h1: begin e.bus_n = 3'b101; e.imm = 4'h0; e.st_n = 4'b0111; end            // MOV A,B
         4'h2: begin e.bus_n = 3'b110; e.imm = 4'h0; e.st_n = 4'b0111; end            // IN A
         4'h3: begin e.st_n = 4'b0111; end                                            // MOV A,Im
         4'h4: begin e.bus_n = 3'b011; e.imm = 4'h0; e.st_n = 4'b1011; end            // MOV B,A
         4'h5: begin e.bus_n = 3'b101; e.st_n = 4'b1011; e.cflag = carry; end         // ADD B,Im
         4'h6: begin e.bus_n = 3'b110; e.imm = 4'h0; e.st_n = 4'b1011; end            // IN B
         4'h7: begin e.st_n = 4'b1011; end                                            // MOV B,Im
         4'h9: begin e.bus_n = 3'b101; e.imm = 4'h0; e.st_n = 4'b1101; end            // OUT B
         4'hB: begin e.st_n = 4'b1101; end                                            // OUT Im
         4'hE: begin if (!cf_before) begin e.st_n = 4'b1110; e.pc_inc = 1'b0; end end // JNC
         4'hF: begin e.st_n = 4'b1110; e.pc_inc = 1'b0; end                           // JMP
         default: ;                                                                   // NOP
      endcase
      return e;
   endfunction

   // Monitor
   always @(negedge CLK) begin
      if (mon_en) begin
         if (cf_pending) begin
            chk("cflag", {31'd0, CFLAG}, {31'd0, cf_exp});
            cf_pending = 1'b0;
         end
         case (PHASE)
            2'b00: chk("fetch_idle",
                       {24'd0, nA_OUT, nB_OUT, nIN_OUT, nA_ST, nB_ST, nOUT_ST, nPC_LD, PC_INC},
                       32'hFE);
            2'b01: begin
               if (sb.size() == 0) fail_now("decode_unexpected");
               else begin
                  chk("decode_bus", {29'd0, nA_OUT, nB_OUT, nIN_OUT}, {29'd0, sb[0].bus_n});
                  chk("decode_imm", {28'd0, IMM}, {28'd0, sb[0].imm});
                  chk("decode_no_strobe", {27'd0, nA_ST, nB_ST, nOUT_ST, nPC_LD, PC_INC}, 32'h1E);
               end
            end
            2'b10: begin
               if (sb.size() == 0) fail_now("exec_unexpected");
               else begin
                  mon_e = sb.pop_front();
                  chk("exec_bus", {29'd0, nA_OUT, nB_OUT, nIN_OUT}, {29'd0, mon_e.bus_n});
                  chk("exec_imm", {28'd0, IMM}, {28'd0, mon_e.imm});
                  chk("exec_strobes", {28'd0, nA_ST, nB_ST, nOUT_ST, nPC_LD}, {28'd0, mon_e.st_n});
                  chk("exec_pc_inc", {31'd0, PC_INC}, {31'd0, mon_e.pc_inc});
                  cf_pending = 1'b1;
                  cf_exp     = mon_e.cflag;
               end
            end
            default: fail_now("phase_illegal");
         endcase
      end
   end

   task automatic issue(input logic [7:0] rom, input logic carry, input int unsigned stalls);
      exp_t e;
      for (int unsigned i = 0; i < stalls; i++) begin
         STEP_EN  = 1'b0;
         ROM_DATA = 8'($urandom);
         CARRY_IN = 1'($urandom);
         @(posedge CLK); #1;
         chk("stall_phase", {30'd0, PHASE}, 32'd0);
      end
      STEP_EN  = 1'b1;
      ROM_DATA = rom;
      CARRY_IN = carry;
      e = model(rom, carry, m_cflag);
      m_cflag = e.cflag;
      sb.push_back(e);
      @(posedge CLK); #1;
      STEP_EN  = 1'($urandom);
      ROM_DATA = 8'($urandom);
      @(posedge CLK); #1;
      STEP_EN  = 1'($urandom);
      @(posedge CLK); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_phase", {30'd0, PHASE}, 32'd0);
      chk("rst_cflag", {31'd0, CFLAG}, 32'd0);
      chk("rst_imm", {28'd0, IMM}, 32'd0);
      chk("rst_outs", {24'd0, nA_OUT, nB_OUT, nIN_OUT, nA_ST, nB_ST, nOUT_ST, nPC_LD, PC_INC},
          32'hFE);
      RST = 1'b0;
      mon_en = 1'b1;

      issue(8'h35, 1'b0, 0);   // MOV A,5
      issue(8'h0F, 1'b1, 0);   // ADD A,F with carry
      issue(8'hE3, 1'b0, 0);   // JNC not taken, clears flag
      issue(8'hE3, 1'b0, 0);   // JNC taken
      issue(8'h9A, 1'b0, 0);   // OUT B
      issue(8'h80, 1'b0, 0);   // NOP
      issue(8'h80, 1'b1, 5);   // NOP after 5 stalled FETCH cycles
      issue(8'h57, 1'b1, 1);   // ADD B,7 with carry -> flag set

      // Reset landing in EXEC: strobe must vanish, state returns to FETCH.
      @(negedge CLK); #1;
      mon_en   = 1'b0;
      STEP_EN  = 1'b1;
      ROM_DATA = 8'h35;
      @(posedge CLK); #1;
      STEP_EN = 1'b0;
      @(posedge CLK); #1;
      chk("pre_rst_nA_ST", {31'd0, nA_ST}, 32'd0);
      RST = 1'b1;
      #1;
      chk("rst_exec_nA_ST", {31'd0, nA_ST}, 32'd1);
      chk("rst_exec_pc_inc", {31'd0, PC_INC}, 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      chk("rst_exec_phase", {30'd0, PHASE}, 32'd0);
      chk("rst_exec_cflag", {31'd0, CFLAG}, 32'd0);
      m_cflag    = 1'b0;
      cf_pending = 1'b0;
      mon_en     = 1'b1;

      for (int n = 0; n < 300; n++) begin
         issue(8'($urandom), 1'($urandom), $urandom_range(0, 2));
      end

      repeat (2) @(negedge CLK);
      chk("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
